fadd_pipe: RTL and testbench
============================

FADD_PIPE -- requirements
Module: fadd_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth. WIDTH SHALL be an integer multiple of STAGES. Chunk width CW = WIDTH/STAGES.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port a, input, WIDTH bits: operand A.
REQ-006 SHALL have port b, input, WIDTH bits: operand B.
REQ-007 SHALL have port cin, input, 1 bit: carry-in to bit 0.
REQ-008 SHALL have port in_valid, input, 1 bit: a/b/cin hold a valid vector.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a vector this cycle.
REQ-010 SHALL have port sum, output, WIDTH bits: (a+b+cin) mod 2^WIDTH.
REQ-011 SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-012 SHALL have port out_valid, output, 1 bit: sum/cout hold a valid result.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.

Function
REQ-014 Stage k (0..STAGES-1) SHALL add chunk k of a and b (bits k*CW..k*CW+CW-1) plus the carry registered by stage k-1 (cin for stage 0), and register the CW-bit partial sum and carry.
REQ-015 Operand chunks not yet consumed and partial sums already produced SHALL travel with their vector through per-stage registers, so every stage holds exactly one vector's data.
REQ-016 Each stage SHALL carry a valid bit. Global advance enable: adv = !out_valid || out_ready.
REQ-017 in_ready SHALL equal adv (combinational). A transfer occurs when in_valid && in_ready.
REQ-018 When adv=1, every stage register SHALL shift forward one stage. The stage-0 valid bit SHALL load in_valid. When adv=0, all stage registers and valid bits SHALL hold.
REQ-019 Latency SHALL be exactly STAGES cycles from accept to out_valid when no stall occurs. Throughput SHALL be one vector per cycle.
REQ-020 out_valid SHALL be the last-stage valid bit. sum and cout SHALL be the last-stage registers, stable while out_valid && !out_ready.
REQ-021 Results SHALL emerge in acceptance order. No vector SHALL be dropped or duplicated under any out_ready pattern.
REQ-022 Bubbles (in_valid=0 while adv=1) SHALL propagate as invalid stages. Data in invalid stages is don't-care but SHALL NOT assert out_valid.
REQ-023 Carry SHALL ripple across all chunk boundaries. Example: a=0x0FFF, b=0x0001 SHALL produce 0x1000, cout=0.
REQ-024 STAGES=1 SHALL reduce to a single registered WIDTH-bit adder with latency 1.

Reset
REQ-025 While rst=1, all valid bits, sum, cout (and ovf when compiled in) SHALL be 0 immediately, without waiting for a clock edge.
REQ-026 After reset, out_valid=0 and in_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight vectors. No result SHALL appear for vectors accepted before reset.

Configuration
REQ-028 Macro FADD_PIPE_OVF_EN, when defined, SHALL add output port ovf (1 bit): two's-complement signed overflow of a+b+cin, i.e. carry into MSB XOR carry out of MSB.
REQ-029 ovf SHALL be registered alongside sum/cout and be valid with out_valid.
REQ-030 Without FADD_PIPE_OVF_EN, port ovf and its logic SHALL be absent. All other behaviour SHALL be unchanged.

Verification (WIDTH=16, STAGES=4 unless noted)
REQ-031 Accept a=0x0000, b=0x0001, cin=0 with out_ready=1 -> out_valid high exactly 4 cycles later, sum=0x0001, cout=0.
REQ-032 a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1. a=0xAAAA, b=0x5556, cin=0 -> sum=0x0000, cout=1 (full carry ripple through all chunks).
REQ-033 Five back-to-back vectors; out_ready held low for 3 cycles once the first result appears -> in_ready=0 during the stall, sum/cout held, all five results correct and in order, no extra out_valid pulses.
REQ-034 Assert rst for 1 cycle with 3 vectors in flight -> out_valid=0 and outputs 0 immediately; next accepted vector 0x0010+0x0020 -> 0x0030 after 4 cycles; no stale results.
REQ-035 With FADD_PIPE_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0. 0x8000+0xFFFF -> sum=0x7FFF, ovf=1, cout=1.
REQ-036 Repeat REQ-031/REQ-032 with WIDTH=8, STAGES=1 and with WIDTH=8, STAGES=8 -> latency 1 and 8 respectively, sums correct mod 256.

Source files
------------

// File: rtl/fadd_pipe.sv
// fadd_pipe: pipelined ripple-carry adder with valid/ready flow control.
// Each of the STAGES stages adds one CW-bit chunk (CW = WIDTH/STAGES) plus
// the carry registered by the stage before it. Operands shift down by one
// chunk per stage, so the chunk to add always sits in bits [CW-1:0]. The
// partial sum grows upward as each stage ORs its chunk into place.
// One global advance enable moves or freezes the whole pipeline.
// WIDTH must be an integer multiple of STAGES.
// Optional feature: define FADD_PIPE_OVF_EN to add the registered signed
// overflow output 'ovf'.

module fadd_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef FADD_PIPE_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = WIDTH / STAGES;

    // Per-stage pipeline registers; index STAGES-1 drives the outputs.
    logic             valid_reg [STAGES];
    logic [WIDTH-1:0] a_reg     [STAGES];
    logic [WIDTH-1:0] b_reg     [STAGES];
    logic [WIDTH-1:0] sum_reg   [STAGES];
    logic             carry_reg [STAGES];

`ifdef FADD_PIPE_OVF_EN
    logic             ovf_reg;
`endif

    logic adv;

    // The pipeline moves whenever the output slot is empty or being drained.
    assign adv      = !valid_reg[STAGES-1] || out_ready;
    assign in_ready = adv;

    assign out_valid = valid_reg[STAGES-1];
    assign sum       = sum_reg[STAGES-1];
    assign cout      = carry_reg[STAGES-1];
`ifdef FADD_PIPE_OVF_EN
    assign ovf       = ovf_reg;
`endif

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic             c_in;
        logic             v_in;
        logic [CW:0]      chunk;
        logic [WIDTH-1:0] chunk_ext;
        logic [WIDTH-1:0] sum_next;

        if (gi == 0) begin : g_first
            assign a_in   = a;
            assign b_in   = b;
            assign sum_in = '0;
            assign c_in   = cin;
            assign v_in   = in_valid;
        end else begin : g_next
            assign a_in   = a_reg[gi-1];
            assign b_in   = b_reg[gi-1];
            assign sum_in = sum_reg[gi-1];
            assign c_in   = carry_reg[gi-1];
            assign v_in   = valid_reg[gi-1];
        end

        // The chunk for this stage is always the low CW bits of the shifted operands.
        assign chunk     = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};
        assign chunk_ext = WIDTH'(chunk[CW-1:0]);

        // Bits above this chunk are still zero, so OR drops the new chunk into place.
        always_comb begin
            sum_next = sum_in | (chunk_ext << (gi * CW));
        end

        // Stage register: shift on advance, freeze otherwise; reset clears everything.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg[gi] <= 1'b0;
                a_reg[gi]     <= '0;
                b_reg[gi]     <= '0;
                sum_reg[gi]   <= '0;
                carry_reg[gi] <= 1'b0;
            end else if (adv) begin
                valid_reg[gi] <= v_in;
                a_reg[gi]     <= a_in >> CW;
                b_reg[gi]     <= b_in >> CW;
                sum_reg[gi]   <= sum_next;
                carry_reg[gi] <= chunk[CW];
            end
        end

`ifdef FADD_PIPE_OVF_EN
        if (gi == STAGES - 1) begin : g_ovf
            // Signed overflow: both operands share a sign that the result does not.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_reg <= 1'b0;
                end else if (adv) begin
                    ovf_reg <= (a_in[CW-1] == b_in[CW-1]) && (chunk[CW-1] != a_in[CW-1]);
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_fadd_pipe.sv
// Testbench for fadd_pipe: directed table vectors, stall and mid-flight
// reset sequences, randomized traffic against a queue-based arithmetic
// model, and latency checks on 8-bit single-stage and eight-stage builds.

module tb_fadd_pipe;

    localparam int STAGES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b;
    logic        cin, in_valid, out_ready;
    logic        in_ready, out_valid, cout;
    logic [15:0] sum;
`ifdef FADD_PIPE_OVF_EN
    logic        ovf, ov1, ov8;
`endif

    logic [7:0]  a8, b8;
    logic        cin8, iv8, or8;
    logic        ir1, ovl1, c1, ir8, ovl8, c8;
    logic [7:0]  s1, s8;

    always #5 clk = ~clk;

    fadd_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .in_ready(in_ready), .sum(sum), .cout(cout),
`ifdef FADD_PIPE_OVF_EN
        .ovf(ovf),
`endif
        .out_valid(out_valid), .out_ready(out_ready));

    fadd_pipe #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .in_ready(ir1), .sum(s1), .cout(c1),
`ifdef FADD_PIPE_OVF_EN
        .ovf(ov1),
`endif
        .out_valid(ovl1), .out_ready(or8));

    fadd_pipe #(.WIDTH(8), .STAGES(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .in_ready(ir8), .sum(s8), .cout(c8),
`ifdef FADD_PIPE_OVF_EN
        .ovf(ov8),
`endif
        .out_valid(ovl8), .out_ready(or8));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        v;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        v;
        int          acc_cycle;
        int          acc_stall;
    } exp_t;

    vec_t        tbl [7];
    exp_t        q[$];
    exp_t        next_exp;
    int          n_vec = 0;
    int          n_bad = 0;
    int          cycle = 0;
    int          stall_cnt = 0;
    logic        accepted;
    logic        hold_pending = 1'b0;
    logic [15:0] hold_sum;
    logic        hold_cout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic for sum/carry, signed range test for overflow.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
        exp_t        m;
        logic [16:0] full;
        int          s;
        full = {1'b0, x} + {1'b0, y} + {16'b0, c};
        s    = int'($signed(x)) + int'($signed(y)) + int'(c);
        m.s  = full[15:0];
        m.co = full[16];
        m.v  = (s > 32767) || (s < -32768);
        m.acc_cycle = 0;
        m.acc_stall = 0;
        return m;
    endfunction

    function automatic exp_t from_tbl(input vec_t t);
        exp_t m;
        m.s = t.s; m.co = t.co; m.v = t.v; m.acc_cycle = 0; m.acc_stall = 0;
        return m;
    endfunction

    // One cycle: called just after a negedge with inputs already driven.
    task automatic tick();
        logic exp_ready;
        exp_t e;
        int   lat;
        #2;
        exp_ready = !out_valid || out_ready;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        if (hold_pending) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_sum", {16'b0, sum}, {16'b0, hold_sum});
            chk("hold_cout", {31'b0, cout}, {31'b0, hold_cout});
            hold_pending = 1'b0;
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", {31'b0, out_valid}, 32'd0);
            end else if (out_ready) begin
                e   = q.pop_front();
                lat = cycle - e.acc_cycle;
                chk("sum", {16'b0, sum}, {16'b0, e.s});
                chk("cout", {31'b0, cout}, {31'b0, e.co});
`ifdef FADD_PIPE_OVF_EN
                chk("ovf", {31'b0, ovf}, {31'b0, e.v});
`endif
                chk("latency", lat, STAGES + (stall_cnt - e.acc_stall));
            end else begin
                hold_pending = 1'b1;
                hold_sum     = sum;
                hold_cout    = cout;
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            next_exp.acc_cycle = cycle;
            next_exp.acc_stall = stall_cnt;
            q.push_back(next_exp);
        end
        if (!exp_ready) stall_cnt++;
        cycle++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_one(input vec_t t);
        a = t.a; b = t.b; cin = t.c; in_valid = 1'b1;
        next_exp = from_tbl(t);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (accepted) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 30 && q.size() > 0; k++) tick();
        for (int k = 0; k < 3; k++) tick();
        chk(name, q.size(), 0);
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c,
                        input logic [7:0] es, input logic ec);
        int lat1, lat8;
        logic [7:0] g1, g8;
        logic gc1, gc8;
        lat1 = 0; lat8 = 0; g1 = 8'h0; g8 = 8'h0; gc1 = 1'b0; gc8 = 1'b0;
        #2;
        chk("w8s1_in_ready", {31'b0, ir1}, 32'd1);
        chk("w8s8_in_ready", {31'b0, ir8}, 32'd1);
        a8 = x; b8 = y; cin8 = c; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            #2;
            if (ovl1 && lat1 == 0) begin lat1 = n; g1 = s1; gc1 = c1; end
            if (ovl8 && lat8 == 0) begin lat8 = n; g8 = s8; gc8 = c8; end
            @(posedge clk);
            @(negedge clk);
        end
        chk("w8s1_latency", lat1, 1);
        chk("w8s1_sum", {24'b0, g1}, {24'b0, es});
        chk("w8s1_cout", {31'b0, gc1}, {31'b0, ec});
        chk("w8s8_latency", lat8, 8);
        chk("w8s8_sum", {24'b0, g8}, {24'b0, es});
        chk("w8s8_cout", {31'b0, gc8}, {31'b0, ec});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx, stall_left;
        logic started;

        tbl[0] = '{16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[2] = '{16'hAAAA, 16'h5556, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[6] = '{16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0};

        rst = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a8 = '0; b8 = '0; cin8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", {16'b0, sum}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_w8s8_valid", {31'b0, ovl8}, 32'd0);
        rst = 1'b0;

        // Table vectors one at a time through an otherwise empty pipeline.
        for (int i = 0; i < 7; i++) begin
            send_one(tbl[i]);
            drain("table_drain");
        end

        // Five back-to-back vectors with a three-cycle stall at the first result.
        idx = 0; stall_left = 3; started = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!started && out_valid) started = 1'b1;
            if (started && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (idx < 5) begin
                a = tbl[idx].a; b = tbl[idx].b; cin = tbl[idx].c; in_valid = 1'b1;
                next_exp = from_tbl(tbl[idx]);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (accepted) idx++;
            if (idx == 5 && q.size() == 0 && !hold_pending) break;
        end
        chk("b2b_accepted", idx, 5);
        drain("b2b_drain");

        // Three vectors in flight, then an asynchronous reset mid-cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'h1111 * 16'(i + 1); b = 16'h0101; cin = 1'b1; in_valid = 1'b1;
            next_exp = model(a, b, cin);
            tick();
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_sum", {16'b0, sum}, 32'd0);
        chk("async_rst_cout", {31'b0, cout}, 32'd0);
        chk("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef FADD_PIPE_OVF_EN
        chk("async_rst_ovf", {31'b0, ovf}, 32'd0);
`endif
        q.delete();
        hold_pending = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send_one(tbl[6]);
        drain("post_reset_drain");

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            next_exp = model(a, b, cin);
            tick();
        end
        drain("random_drain");

        // 8-bit builds: single stage and one bit per stage.
        run8(8'h00, 8'h01, 1'b0, 8'h01, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run8(8'hAA, 8'h56, 1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
